// File: rtl/issue_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : issue_scheduler_if
// Description : Issue-queue <-> scheduler <-> execution-unit signal bundle.
//               master = issue-queue / execution-unit side (drives requests),
//               slave  = scheduler side (drives grants and status).
// Revision    : 1.0 - initial release
// ============================================================================
interface issue_scheduler_if #(
  parameter int DEPTH        = 16,
  parameter int MAX_INFLIGHT = 4
);
  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(MAX_INFLIGHT) + 1;

  // Requests and control towards the scheduler
  logic [DEPTH-1:0]   req_i;
  logic               flush_i;
  logic               issue_ready_i;
  logic               complete_i;

  // Grant and status from the scheduler
  logic               issue_valid_o;
  logic [DEPTH-1:0]   grant_o;
  logic [c_IDX_W-1:0] issue_idx_o;
  logic [DEPTH-1:0]   dealloc_o;
  logic [c_CNT_W-1:0] inflight_o;
  logic               stall_o;

  modport master (
    output req_i, flush_i, issue_ready_i, complete_i,
    input  issue_valid_o, grant_o, issue_idx_o, dealloc_o, inflight_o, stall_o
  );

  modport slave (
    input  req_i, flush_i, issue_ready_i, complete_i,
    output issue_valid_o, grant_o, issue_idx_o, dealloc_o, inflight_o, stall_o
  );
endinterface
`default_nettype wire

// File: rtl/issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : issue_scheduler
// Description : Round-robin issue arbiter over DEPTH issue-queue entries with a
//               registered one-hot grant, ready/valid handshake towards the
//               execution unit, back-to-back issue and an in-flight limiter.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_scheduler #(
  parameter int DEPTH        = 16,
  parameter int MAX_INFLIGHT = 4
) (
  input  wire                  clk,
  input  wire                  resetn,
  issue_scheduler_if.slave     sched_if
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [c_CNT_W-1:0] c_MAX     = c_CNT_W'(MAX_INFLIGHT);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);
  localparam logic [DEPTH-1:0]   c_ONE_HOT = {{(DEPTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             r_state;
  logic [DEPTH-1:0]   r_grant;
  logic [c_IDX_W-1:0] r_idx;
  logic [c_IDX_W-1:0] r_rr_ptr;
  logic [DEPTH-1:0]   r_mask;
  logic [c_CNT_W-1:0] r_inflight;

  logic               w_hold;
  logic               w_accept;
  logic               w_dec;
  logic [DEPTH-1:0]   w_elig;
  logic [DEPTH-1:0]   w_pick_vec;
  logic [c_IDX_W-1:0] w_ptr_hs;
  logic [c_IDX_W-1:0] w_pick_ptr;
  logic [c_IDX_W:0]   w_pick;
  logic               w_found;
  logic [c_IDX_W-1:0] w_sel_idx;
  logic [c_CNT_W-1:0] w_inflight_nxt;
  logic               w_room;

  // First set bit of vec at or after ptr, wrapping; result is {found, index}.
  // DEPTH is a power of two, so the index addition wraps naturally.
  function automatic logic [c_IDX_W:0] rr_pick(input logic [DEPTH-1:0]   vec,
                                               input logic [c_IDX_W-1:0] ptr);
    logic               found;
    logic [c_IDX_W-1:0] idx;
    logic [c_IDX_W-1:0] k;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      k = ptr + c_IDX_W'(i);
      if (!found && vec[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
    return {found, idx};
  endfunction

  // A flush kills the presented grant, so it can never count as an accept.
  assign w_hold   = (r_state == HOLD);
  assign w_accept = w_hold & sched_if.issue_ready_i & ~sched_if.flush_i;

  // The entry accepted last cycle may still show its req bit; keep it out.
  assign w_elig   = sched_if.req_i & ~r_mask;
  assign w_ptr_hs = r_idx + c_IDX_ONE;

  // A completion with nothing outstanding is dropped.
  assign w_dec = sched_if.complete_i & (r_inflight != '0);

  // Next-cycle in-flight count; the issue limit is checked against this value
  // so a same-cycle completion frees a slot immediately.
  always_comb begin
    w_inflight_nxt = r_inflight;
    if (w_accept && !w_dec) begin
      w_inflight_nxt = r_inflight + c_CNT_ONE;
    end else if (!w_accept && w_dec) begin
      w_inflight_nxt = r_inflight - c_CNT_ONE;
    end
  end

  assign w_room = (w_inflight_nxt < c_MAX);

  // One picker serves both the fresh grant from IDLE and the back-to-back
  // grant on a handshake (new pointer, accepted entry excluded).
  assign w_pick_vec = w_accept ? (w_elig & ~r_grant) : w_elig;
  assign w_pick_ptr = w_accept ? w_ptr_hs : r_rr_ptr;
  assign w_pick     = rr_pick(w_pick_vec, w_pick_ptr);
  assign w_found    = w_pick[c_IDX_W];
  assign w_sel_idx  = w_pick[c_IDX_W-1:0];

  // Scheduler FSM with registered grant, index, pointer, mask and counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_idx      <= '0;
      r_rr_ptr   <= '0;
      r_mask     <= '0;
      r_inflight <= '0;
    end else if (sched_if.flush_i) begin
      // Round-robin pointer deliberately survives a flush.
      r_state    <= IDLE;
      r_grant    <= '0;
      r_idx      <= '0;
      r_mask     <= '0;
      r_inflight <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      r_mask     <= w_accept ? r_grant : '0;
      if (w_accept) begin
        r_rr_ptr <= w_ptr_hs;
      end
      case (r_state)
        IDLE: begin
          if (w_found && w_room) begin
            r_grant <= c_ONE_HOT << w_sel_idx;
            r_idx   <= w_sel_idx;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          // Without an accept the grant is frozen regardless of req_i.
          if (w_accept) begin
            if (w_found && w_room) begin
              r_grant <= c_ONE_HOT << w_sel_idx;
              r_idx   <= w_sel_idx;
              r_state <= HOLD;
            end else begin
              r_grant <= '0;
              r_idx   <= '0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign sched_if.issue_valid_o = w_hold;
  assign sched_if.grant_o       = r_grant;
  assign sched_if.issue_idx_o   = r_idx;
  assign sched_if.dealloc_o     = w_accept ? r_grant : '0;
  assign sched_if.inflight_o    = r_inflight;
  assign sched_if.stall_o       = (|sched_if.req_i) & (r_inflight == c_MAX);

endmodule
`default_nettype wire

// File: tb/tb_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_scheduler
// Description : Directed self-checking bench for issue_scheduler. The bench
//               plays the issue queue: when auto_clr is set, an entry's req
//               bit drops at the edge where its dealloc_o pulse is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_scheduler;
  localparam int DEPTH        = 16;
  localparam int MAX_INFLIGHT = 4;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic auto_clr = 1'b0;
  logic [DEPTH-1:0] last_dealloc;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  issue_scheduler_if #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAX_INFLIGHT)) u_if ();

  issue_scheduler #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAX_INFLIGHT)) u_dut (
    .clk      (clk),
    .resetn   (resetn),
    .sched_if (u_if)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Capture dealloc just before the edge, advance one cycle, retire the entry.
  task automatic tick();
    #1;
    last_dealloc = u_if.dealloc_o;
    @(posedge clk);
    #1;
    if (auto_clr) u_if.req_i = u_if.req_i & ~last_dealloc;
  endtask

  task automatic do_reset();
    resetn             = 1'b0;
    auto_clr           = 1'b0;
    u_if.req_i         = '0;
    u_if.flush_i       = 1'b0;
    u_if.issue_ready_i = 1'b0;
    u_if.complete_i    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    #1;
    check_eq("rst_valid",    u_if.issue_valid_o, 0);
    check_eq("rst_grant",    u_if.grant_o,       0);
    check_eq("rst_idx",      u_if.issue_idx_o,   0);
    check_eq("rst_dealloc",  u_if.dealloc_o,     0);
    check_eq("rst_inflight", u_if.inflight_o,    0);
    check_eq("rst_stall",    u_if.stall_o,       0);

    // Two requests, always ready: 0x1 then 0x4, then idle
    auto_clr = 1'b1;
    u_if.req_i = 16'h0005;
    u_if.issue_ready_i = 1'b1;
    #1;
    check_eq("rr_c0_valid", u_if.issue_valid_o, 0);
    tick();
    check_eq("rr_c1_grant",   u_if.grant_o,   16'h0001);
    check_eq("rr_c1_dealloc", u_if.dealloc_o, 16'h0001);
    tick();
    check_eq("rr_c2_grant",    u_if.grant_o,     16'h0004);
    check_eq("rr_c2_idx",      u_if.issue_idx_o, 2);
    check_eq("rr_c2_dealloc",  u_if.dealloc_o,   16'h0004);
    check_eq("rr_c2_inflight", u_if.inflight_o,  1);
    tick();
    check_eq("rr_c3_valid",    u_if.issue_valid_o, 0);
    check_eq("rr_c3_grant",    u_if.grant_o,       0);
    check_eq("rr_c3_dealloc",  u_if.dealloc_o,     0);
    check_eq("rr_c3_inflight", u_if.inflight_o,    2);

    // Grant hold while not ready, req changes underneath
    do_reset();
    auto_clr = 1'b1;
    u_if.req_i = 16'h0002;
    tick();
    check_eq("hold_c1_grant", u_if.grant_o, 16'h0002);
    u_if.req_i = 16'h0008;
    tick();
    check_eq("hold_c2_grant", u_if.grant_o,     16'h0002);
    check_eq("hold_c2_idx",   u_if.issue_idx_o, 1);
    tick();
    check_eq("hold_c3_grant",   u_if.grant_o,   16'h0002);
    check_eq("hold_c3_dealloc", u_if.dealloc_o, 0);
    u_if.issue_ready_i = 1'b1;
    #1;
    check_eq("hold_acc_dealloc", u_if.dealloc_o, 16'h0002);
    tick();
    check_eq("hold_b2b_grant",    u_if.grant_o,       16'h0008);
    check_eq("hold_b2b_valid",    u_if.issue_valid_o, 1);
    check_eq("hold_b2b_inflight", u_if.inflight_o,    1);

    // In-flight limit: four issues, stall, one completion releases idx 4
    do_reset();
    auto_clr = 1'b1;
    u_if.req_i = 16'hFFFF;
    u_if.issue_ready_i = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("lim_idx%0d", k),   u_if.issue_idx_o,   k);
      check_eq($sformatf("lim_valid%0d", k), u_if.issue_valid_o, 1);
      tick();
    end
    check_eq("lim_valid_off", u_if.issue_valid_o, 0);
    check_eq("lim_inflight",  u_if.inflight_o,    4);
    check_eq("lim_stall",     u_if.stall_o,       1);
    check_eq("lim_dealloc",   u_if.dealloc_o,     0);
    u_if.complete_i = 1'b1;
    tick();
    u_if.complete_i = 1'b0;
    #1;
    check_eq("lim_cpl_valid",    u_if.issue_valid_o, 1);
    check_eq("lim_cpl_idx",      u_if.issue_idx_o,   4);
    check_eq("lim_cpl_inflight", u_if.inflight_o,    3);
    check_eq("lim_cpl_stall",    u_if.stall_o,       0);

    // Wrap-around: accept idx 14 so the pointer sits at 15
    do_reset();
    auto_clr = 1'b1;
    u_if.req_i = 16'h4000;
    u_if.issue_ready_i = 1'b1;
    tick();
    check_eq("wrap_pre_idx", u_if.issue_idx_o, 14);
    tick();
    check_eq("wrap_pre_idle", u_if.issue_valid_o, 0);
    u_if.req_i = 16'h8001;
    tick();
    check_eq("wrap_g1_grant", u_if.grant_o,     16'h8000);
    check_eq("wrap_g1_idx",   u_if.issue_idx_o, 15);
    tick();
    check_eq("wrap_g2_grant", u_if.grant_o,     16'h0001);
    check_eq("wrap_g2_idx",   u_if.issue_idx_o, 0);

    // Flush in HOLD with ready high and three in flight
    do_reset();
    auto_clr = 1'b1;
    u_if.req_i = 16'h000F;
    u_if.issue_ready_i = 1'b1;
    repeat (4) tick();
    check_eq("fl_pre_idx",      u_if.issue_idx_o, 3);
    check_eq("fl_pre_inflight", u_if.inflight_o,  3);
    u_if.flush_i = 1'b1;
    #1;
    check_eq("fl_dealloc", u_if.dealloc_o, 0);
    tick();
    u_if.flush_i = 1'b0;
    #1;
    check_eq("fl_valid",    u_if.issue_valid_o, 0);
    check_eq("fl_inflight", u_if.inflight_o,    0);
    check_eq("fl_grant",    u_if.grant_o,       0);
    tick();
    // Pointer kept at 3 and mask cleared: the surviving entry 3 re-issues
    check_eq("fl_regrant", u_if.grant_o, 16'h0008);

    // Asynchronous reset between edges while holding a grant
    do_reset();
    u_if.req_i = 16'h0020;
    tick();
    check_eq("ar_pre_grant", u_if.grant_o, 16'h0020);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("ar_valid",    u_if.issue_valid_o, 0);
    check_eq("ar_grant",    u_if.grant_o,       0);
    check_eq("ar_idx",      u_if.issue_idx_o,   0);
    check_eq("ar_dealloc",  u_if.dealloc_o,     0);
    check_eq("ar_inflight", u_if.inflight_o,    0);
    u_if.req_i = 16'h0010;
    #1;
    resetn = 1'b1;
    tick();
    check_eq("ar_rel_grant", u_if.grant_o,       16'h0010);
    check_eq("ar_rel_idx",   u_if.issue_idx_o,   4);
    check_eq("ar_rel_valid", u_if.issue_valid_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
